// File: rtl/fu_dispatch_pkg.sv
// Shared widths and payload types for the FU issue/response link.
package fu_dispatch_pkg;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned NUM_OPS = 3;
    localparam int unsigned NUM_OUT = 3;
    localparam int unsigned PRN_W   = 7;
    localparam int unsigned ID_W    = 6;
    localparam int unsigned INST_W  = 32;

    // Issue-side request: one renamed, operand-ready instruction.
    typedef struct packed {
        logic [INST_W-1:0]                inst;
        logic [ID_W-1:0]                  inst_id;
        logic [NUM_OPS-1:0][XLEN-1:0]     op;
        logic [NUM_OUT-1:0][PRN_W-1:0]    out_prn;
    } fu_req_t;

    // Response from the FU, held in the result buffer until writeback.
    typedef struct packed {
        logic [NUM_OUT-1:0][XLEN-1:0]     data;
        logic [NUM_OUT-1:0]               data_valid;
        logic [NUM_OUT-1:0][PRN_W-1:0]    prn;
        logic [ID_W-1:0]                  inst_id;
    } fu_resp_t;

endpackage

// File: rtl/fu_dispatch_sync_fifo.sv
// Generic synchronous FIFO with a count register; push is honoured when full only alongside a pop.
module fu_dispatch_sync_fifo
    import fu_dispatch_pkg::*;
#(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic             i_pop,
    input  T                 i_data,
    output T                 o_data,
    output logic [CNT_W-1:0] o_count
);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    T                 r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_push = i_push && (!w_full || i_pop);
    assign w_do_pop  = i_pop && !w_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Pointer, count and storage update; pointers wrap naturally at power-of-2 depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

endmodule

// File: rtl/fu_dispatch.sv
// Issue-side driver for one functional unit: in-order issue queue, credit-protected result buffer.
module fu_dispatch
    import fu_dispatch_pkg::*;
#(
    parameter int unsigned IQ_DEPTH = 4,
    parameter int unsigned RB_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_flush,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    input  logic [INST_W-1:0]         i_in_inst,
    input  logic [ID_W-1:0]           i_in_inst_id,
    input  logic [NUM_OPS*XLEN-1:0]   i_in_op,
    input  logic [NUM_OUT*PRN_W-1:0]  i_in_out_prn,
    output logic                      o_inst_valid,
    output logic [INST_W-1:0]         o_inst,
    output logic [ID_W-1:0]           o_inst_id,
    output logic [NUM_OPS*XLEN-1:0]   o_op,
    output logic [NUM_OUT*PRN_W-1:0]  o_out_prn,
    input  logic                      i_fu_ready,
    input  logic                      i_fu_out_valid,
    input  logic [NUM_OUT*XLEN-1:0]   i_fu_out_data,
    input  logic [NUM_OUT-1:0]        i_fu_out_data_valid,
    input  logic [NUM_OUT*PRN_W-1:0]  i_fu_out_prn,
    input  logic [ID_W-1:0]           i_fu_out_inst_id,
    output logic                      o_wb_valid,
    input  logic                      i_wb_ready,
    output logic [NUM_OUT*XLEN-1:0]   o_wb_data,
    output logic [NUM_OUT-1:0]        o_wb_data_valid,
    output logic [NUM_OUT*PRN_W-1:0]  o_wb_prn,
    output logic [ID_W-1:0]           o_wb_inst_id,
    output logic                      o_err
);

    localparam int unsigned IQ_CW = $clog2(IQ_DEPTH) + 1;
    localparam int unsigned CR_W  = $clog2(RB_DEPTH) + 1;
    localparam int unsigned SUM_W = CR_W + 1;

    fu_req_t  w_in_req;
    fu_req_t  w_iq_head;
    fu_req_t  w_issue_req;
    fu_resp_t w_fu_resp;
    fu_resp_t w_rb_head;

    logic [IQ_CW-1:0] w_iq_count;
    logic [CR_W-1:0]  w_rb_count;
    logic [SUM_W-1:0] w_claimed;
    logic             w_iq_empty;
    logic             w_enq;
    logic             w_issue;
    logic             w_wb_pop;

    fu_req_t          r_issue;
    logic             r_inst_valid;
    logic [CR_W-1:0]  r_credits;
    logic             r_err;

    assign w_in_req  = {i_in_inst, i_in_inst_id, i_in_op, i_in_out_prn};
    assign w_fu_resp = {i_fu_out_data, i_fu_out_data_valid, i_fu_out_prn, i_fu_out_inst_id};

    assign w_iq_empty = (w_iq_count == '0);
    assign o_in_ready = (w_iq_count != IQ_CW'(IQ_DEPTH));
    assign w_enq      = i_in_valid && o_in_ready && !i_flush;

    // An empty queue lets the incoming instruction issue in the cycle it arrives.
    assign w_issue     = (!w_iq_empty || w_enq) && i_fu_ready && (r_credits != '0) && !i_flush;
    assign w_issue_req = w_iq_empty ? w_in_req : w_iq_head;

    assign o_wb_valid = (w_rb_count != '0);
    assign w_wb_pop   = o_wb_valid && i_wb_ready;
    assign {o_wb_data, o_wb_data_valid, o_wb_prn, o_wb_inst_id} = w_rb_head;

    // Every RB slot is either a free credit or holds a result; none left means the FU owes nothing.
    assign w_claimed = SUM_W'(r_credits) + SUM_W'(w_rb_count);

    fu_dispatch_sync_fifo #(
        .T     (fu_req_t),
        .DEPTH (IQ_DEPTH)
    ) u_iq (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (i_flush),
        .i_push  (w_enq && !(w_issue && w_iq_empty)),
        .i_pop   (w_issue && !w_iq_empty),
        .i_data  (w_in_req),
        .o_data  (w_iq_head),
        .o_count (w_iq_count)
    );

    fu_dispatch_sync_fifo #(
        .T     (fu_resp_t),
        .DEPTH (RB_DEPTH)
    ) u_rb (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (1'b0),
        .i_push  (i_fu_out_valid),
        .i_pop   (w_wb_pop),
        .i_data  (w_fu_resp),
        .o_data  (w_rb_head),
        .o_count (w_rb_count)
    );

    // Issue register: one-cycle strobe, payload held between issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst_valid <= 1'b0;
            r_issue      <= '0;
        end else begin
            r_inst_valid <= w_issue;
            if (w_issue) begin
                r_issue <= w_issue_req;
            end
        end
    end

    // Credits track unclaimed RB slots; saturate so a stray response can never wrap them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credits <= CR_W'(RB_DEPTH);
        end else if (w_issue && !w_wb_pop) begin
            r_credits <= r_credits - CR_W'(1);
        end else if (!w_issue && w_wb_pop && (r_credits != CR_W'(RB_DEPTH))) begin
            r_credits <= r_credits + CR_W'(1);
        end
    end

    // Sticky error on a response that no issued instruction accounts for.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (i_fu_out_valid && (w_claimed >= SUM_W'(RB_DEPTH))) begin
            r_err <= 1'b1;
        end
    end

    assign o_inst_valid = r_inst_valid;
    assign o_inst       = r_issue.inst;
    assign o_inst_id    = r_issue.inst_id;
    assign o_op         = r_issue.op;
    assign o_out_prn    = r_issue.out_prn;
    assign o_err        = r_err;

endmodule
